// File: rtl/snn_delay_layer_seq.sv
// Time-multiplexed LIF layer: ternary weights, per-synapse spike delays taken
// from a per-input history shift register, one neuron evaluated per clock.
//
//   state | meaning
//   IDLE  | waiting for step; history shifts when a step is accepted
//   EVAL  | updating neuron idx each enabled cycle; last neuron returns to IDLE
module snn_delay_layer_seq #(
    parameter int NUM_IN    = 8,
    parameter int NUM_OUT   = 8,
    parameter int MP_WIDTH  = 5,
    parameter int DW        = 3,
    parameter int REF_WIDTH = 5
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic                          step,
    input  logic [NUM_IN-1:0]             input_spikes,
    input  logic [NUM_IN*NUM_OUT*2-1:0]   weights,
    input  logic [NUM_IN*NUM_OUT*(DW+1)-1:0] delays,
    input  logic [MP_WIDTH-1:0]           threshold,
    input  logic [MP_WIDTH-1:0]           decay,
    input  logic [REF_WIDTH-1:0]          refractory_period,
    input  logic                          reset_mode,
    output logic [NUM_OUT*MP_WIDTH-1:0]   membrane_potential_out,
    output logic [NUM_OUT-1:0]            output_spikes,
    output logic                          busy,
    output logic                          output_data_ready
);
    localparam int HD = 1 << DW;
    localparam int IW = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;
    localparam int SW = $clog2(NUM_IN + 1) + 1;
    localparam int VW = ((MP_WIDTH > SW) ? MP_WIDTH : SW) + 2;
    localparam logic signed [VW-1:0] ONE   = VW'(1);
    localparam logic signed [VW-1:0] MPMAX = VW'((1 << MP_WIDTH) - 1);

    typedef enum logic {IDLE = 1'b0, EVAL = 1'b1} state_t;

    state_t                 state_q, state_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [HD-1:0]          hist_q [NUM_IN];
    logic [HD-1:0]          hist_d [NUM_IN];
    logic [MP_WIDTH-1:0]    mp_q [NUM_OUT];
    logic [MP_WIDTH-1:0]    mp_d [NUM_OUT];
    logic [REF_WIDTH-1:0]   rc_q [NUM_OUT];
    logic [REF_WIDTH-1:0]   rc_d [NUM_OUT];
    logic [NUM_OUT-1:0]     shadow_q, shadow_d;
    logic [NUM_OUT-1:0]     spk_q, spk_d;
    logic                   busy_q, busy_d;
    logic                   ready_q, ready_d;

    logic signed [VW-1:0]   sum;
    logic signed [VW-1:0]   v_raw;
    logic [MP_WIDTH-1:0]    v_cl;
    logic                   fire;

    // Synaptic sum and clamped candidate potential for the neuron at idx_q.
    always_comb begin
        int         s;
        logic [1:0] w;
        logic [DW:0] dl;
        logic       spk;
        s   = 0;
        w   = '0;
        dl  = '0;
        spk = 1'b0;
        sum = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            s   = int'(idx_q) * NUM_IN + i;
            w   = weights[2*s +: 2];
            dl  = delays[s*(DW+1) +: DW+1];
            spk = dl[DW] ? hist_q[i][dl[DW-1:0]] : hist_q[i][0];
            if (spk && !w[1]) begin
                sum = w[0] ? (sum - ONE) : (sum + ONE);
            end
        end
        v_raw = $signed({{(VW-MP_WIDTH){1'b0}}, mp_q[idx_q]})
              - $signed({{(VW-MP_WIDTH){1'b0}}, decay}) + sum;
        if (v_raw[VW-1]) begin
            v_cl = '0;
        end else if (v_raw > MPMAX) begin
            v_cl = '1;
        end else begin
            v_cl = v_raw[MP_WIDTH-1:0];
        end
        fire = (v_cl >= threshold);
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        hist_d   = hist_q;
        mp_d     = mp_q;
        rc_d     = rc_q;
        shadow_d = shadow_q;
        spk_d    = spk_q;
        busy_d   = busy_q;
        ready_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable && step) begin
                    for (int i = 0; i < NUM_IN; i++) begin
                        hist_d[i] = {hist_q[i][HD-2:0], input_spikes[i]};
                    end
                    idx_d   = '0;
                    state_d = EVAL;
                    busy_d  = 1'b1;
                end
            end
            EVAL: begin
                if (enable) begin
                    if (rc_q[idx_q] != '0) begin
                        rc_d[idx_q]     = rc_q[idx_q] - REF_WIDTH'(1);
                        shadow_d[idx_q] = 1'b0;
                    end else if (fire) begin
                        shadow_d[idx_q] = 1'b1;
                        rc_d[idx_q]     = refractory_period;
                        mp_d[idx_q]     = reset_mode ? (v_cl - threshold) : '0;
                    end else begin
                        shadow_d[idx_q] = 1'b0;
                        mp_d[idx_q]     = v_cl;
                    end
                    // Output vector takes the shadow including this last neuron's bit.
                    if (idx_q == IW'(NUM_OUT - 1)) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        ready_d = 1'b1;
                        spk_d   = shadow_d;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            shadow_q <= '0;
            spk_q    <= '0;
            busy_q   <= 1'b0;
            ready_q  <= 1'b0;
            for (int i = 0; i < NUM_IN; i++) begin
                hist_q[i] <= '0;
            end
            for (int j = 0; j < NUM_OUT; j++) begin
                mp_q[j] <= '0;
                rc_q[j] <= '0;
            end
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
            spk_q    <= spk_d;
            busy_q   <= busy_d;
            ready_q  <= ready_d;
            for (int i = 0; i < NUM_IN; i++) begin
                hist_q[i] <= hist_d[i];
            end
            for (int j = 0; j < NUM_OUT; j++) begin
                mp_q[j] <= mp_d[j];
                rc_q[j] <= rc_d[j];
            end
        end
    end

    for (genvar j = 0; j < NUM_OUT; j++) begin : g_mp_out
        assign membrane_potential_out[j*MP_WIDTH +: MP_WIDTH] = mp_q[j];
    end

    assign output_spikes     = spk_q;
    assign busy              = busy_q;
    assign output_data_ready = ready_q;

endmodule

// File: tb/tb_snn_delay_layer_seq.sv
// Directed bench for snn_delay_layer_seq: table of per-step vectors plus
// hand-written handshake, enable-stall and mid-step reset sequences.
module tb_snn_delay_layer_seq;
    localparam int NI = 8;
    localparam int NO = 8;
    localparam int MW = 5;
    localparam int DW = 3;
    localparam int RW = 5;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   enable;
    logic                   step;
    logic [NI-1:0]          input_spikes;
    logic [NI*NO*2-1:0]     weights;
    logic [NI*NO*(DW+1)-1:0] delays;
    logic [MW-1:0]          threshold;
    logic [MW-1:0]          decay;
    logic [RW-1:0]          refractory_period;
    logic                   reset_mode;
    logic [NO*MW-1:0]       membrane_potential_out;
    logic [NO-1:0]          output_spikes;
    logic                   busy;
    logic                   output_data_ready;

    snn_delay_layer_seq #(
        .NUM_IN(NI), .NUM_OUT(NO), .MP_WIDTH(MW), .DW(DW), .REF_WIDTH(RW)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .step(step),
        .input_spikes(input_spikes), .weights(weights), .delays(delays),
        .threshold(threshold), .decay(decay),
        .refractory_period(refractory_period), .reset_mode(reset_mode),
        .membrane_potential_out(membrane_potential_out),
        .output_spikes(output_spikes), .busy(busy),
        .output_data_ready(output_data_ready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic          rst;
        logic [7:0]    in;
        logic [1:0]    w0, w1, wr;
        logic [3:0]    d00;
        logic [4:0]    thr, dec, rp;
        logic          rm;
        logic [7:0]    exp_spk;
        logic [4:0]    exp_mp0, exp_mp1;
    } vec_t;

    vec_t tv [22];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic set_cfg(input logic [1:0] w0, input logic [1:0] w1,
                           input logic [1:0] wr, input logic [3:0] d00);
        for (int s = 0; s < NI*NO; s++) begin
            weights[2*s +: 2] = (s / NI == 0) ? w0 : ((s / NI == 1) ? w1 : wr);
        end
        delays      = '0;
        delays[3:0] = d00;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rst_mp", 64'(membrane_potential_out), 64'd0);
        chk("rst_spk", 64'(output_spikes), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_ready", 64'(output_data_ready), 64'd0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Returns cycles from accepting edge to ready being visible (0 = timeout).
    task automatic run_step(output int lat);
        bit done;
        @(negedge clk);
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        chk("busy_after_accept", 64'(busy), 64'd1);
        lat  = 0;
        done = 1'b0;
        for (int c = 1; c <= 40 && !done; c++) begin
            @(negedge clk);
            if (output_data_ready) begin
                lat  = c;
                done = 1'b1;
            end
        end
        chk("busy_at_ready", 64'(busy), 64'd0);
    endtask

    initial begin
        int lat;
        int nr;
        int bad;

        reset = 1'b0; enable = 1'b1; step = 1'b0; input_spikes = '0;
        weights = '0; delays = '0; threshold = '0; decay = '0;
        refractory_period = '0; reset_mode = 1'b0;

        //          rst   in     w0     w1     wr     d00   thr dec rp rm  spk    mp0 mp1
        tv[0]  = '{1'b1, 8'h07, 2'b00, 2'b00, 2'b00, 4'h0, 3,  0,  0, 0, 8'hFF, 0,  0};
        tv[1]  = '{1'b1, 8'h01, 2'b00, 2'b10, 2'b10, 4'hA, 1,  0,  0, 0, 8'h00, 0,  0};
        tv[2]  = '{1'b0, 8'h00, 2'b00, 2'b10, 2'b10, 4'hA, 1,  0,  0, 0, 8'h00, 0,  0};
        tv[3]  = '{1'b0, 8'h00, 2'b00, 2'b10, 2'b10, 4'hA, 1,  0,  0, 0, 8'h01, 0,  0};
        tv[4]  = '{1'b0, 8'h00, 2'b00, 2'b10, 2'b10, 4'hA, 1,  0,  0, 0, 8'h00, 0,  0};
        tv[5]  = '{1'b1, 8'hFF, 2'b10, 2'b01, 2'b10, 4'h0, 5,  2,  0, 0, 8'h00, 0,  0};
        tv[6]  = '{1'b0, 8'hFF, 2'b10, 2'b00, 2'b10, 4'h0, 31, 0,  0, 0, 8'h00, 0,  8};
        tv[7]  = '{1'b0, 8'hFF, 2'b10, 2'b00, 2'b10, 4'h0, 31, 0,  0, 0, 8'h00, 0,  16};
        tv[8]  = '{1'b0, 8'hFF, 2'b10, 2'b00, 2'b10, 4'h0, 31, 0,  0, 0, 8'h00, 0,  24};
        tv[9]  = '{1'b0, 8'hFF, 2'b10, 2'b00, 2'b10, 4'h0, 31, 0,  0, 0, 8'h02, 0,  0};
        tv[10] = '{1'b0, 8'hFF, 2'b10, 2'b00, 2'b10, 4'h0, 31, 0,  0, 0, 8'h00, 0,  8};
        tv[11] = '{1'b1, 8'h1F, 2'b00, 2'b10, 2'b10, 4'h0, 3,  0,  2, 0, 8'h01, 0,  0};
        tv[12] = '{1'b0, 8'h1F, 2'b00, 2'b10, 2'b10, 4'h0, 3,  0,  2, 0, 8'h00, 0,  0};
        tv[13] = '{1'b0, 8'h1F, 2'b00, 2'b10, 2'b10, 4'h0, 3,  0,  2, 0, 8'h00, 0,  0};
        tv[14] = '{1'b0, 8'h1F, 2'b00, 2'b10, 2'b10, 4'h0, 3,  0,  2, 0, 8'h01, 0,  0};
        tv[15] = '{1'b0, 8'h1F, 2'b00, 2'b10, 2'b10, 4'h0, 3,  0,  2, 0, 8'h00, 0,  0};
        tv[16] = '{1'b0, 8'h1F, 2'b00, 2'b10, 2'b10, 4'h0, 3,  0,  2, 0, 8'h00, 0,  0};
        tv[17] = '{1'b0, 8'h1F, 2'b00, 2'b10, 2'b10, 4'h0, 3,  0,  2, 0, 8'h01, 0,  0};
        tv[18] = '{1'b1, 8'h1F, 2'b00, 2'b10, 2'b10, 4'h0, 3,  0,  2, 1, 8'h01, 2,  0};
        tv[19] = '{1'b0, 8'h1F, 2'b00, 2'b10, 2'b10, 4'h0, 3,  0,  2, 1, 8'h00, 2,  0};
        tv[20] = '{1'b0, 8'h1F, 2'b00, 2'b10, 2'b10, 4'h0, 3,  0,  2, 1, 8'h00, 2,  0};
        tv[21] = '{1'b0, 8'h1F, 2'b00, 2'b10, 2'b10, 4'h0, 3,  0,  2, 1, 8'h01, 4,  0};

        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        for (int r = 0; r < 22; r++) begin
            if (tv[r].rst) do_reset();
            set_cfg(tv[r].w0, tv[r].w1, tv[r].wr, tv[r].d00);
            input_spikes      = tv[r].in;
            threshold         = tv[r].thr;
            decay             = tv[r].dec;
            refractory_period = tv[r].rp;
            reset_mode        = tv[r].rm;
            run_step(lat);
            chk($sformatf("v%0d_latency", r), 64'(lat), 64'd8);
            chk($sformatf("v%0d_spikes", r), 64'(output_spikes), 64'(tv[r].exp_spk));
            chk($sformatf("v%0d_mp0", r), 64'(membrane_potential_out[0 +: MW]), 64'(tv[r].exp_mp0));
            chk($sformatf("v%0d_mp1", r), 64'(membrane_potential_out[MW +: MW]), 64'(tv[r].exp_mp1));
            @(negedge clk);
            chk($sformatf("v%0d_ready_pulse", r), 64'(output_data_ready), 64'd0);
        end

        // step held high: one acceptance every NUM_OUT+1 cycles
        do_reset();
        set_cfg(2'b10, 2'b10, 2'b10, 4'h0);
        threshold = 5'd31; decay = '0; refractory_period = '0; reset_mode = 1'b0;
        @(negedge clk);
        step = 1'b1;
        nr  = 0;
        bad = 0;
        for (int c = 1; c <= 36; c++) begin
            @(negedge clk);
            if (output_data_ready) begin
                nr++;
                if (c % 9 != 0) bad++;
            end
        end
        step = 1'b0;
        chk("hs_ready_count", 64'(nr), 64'd4);
        chk("hs_ready_phase", 64'(bad), 64'd0);

        // enable low for 3 cycles mid-EVAL delays ready by 3
        repeat (2) @(negedge clk);
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        lat = 0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (output_data_ready && lat == 0) lat = c;
            if (c == 3) enable = 1'b0;
            if (c == 6) enable = 1'b1;
        end
        chk("stall_latency", 64'(lat), 64'd11);

        // step while disabled is dropped
        enable = 1'b0;
        @(negedge clk);
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        @(negedge clk);
        enable = 1'b1;
        repeat (3) @(negedge clk);
        chk("disabled_step_ignored", 64'(busy), 64'd0);

        // reset at idx 4 aborts the step
        do_reset();
        set_cfg(2'b00, 2'b00, 2'b00, 4'h0);
        input_spikes = 8'h07; threshold = 5'd4; decay = '0;
        refractory_period = '0; reset_mode = 1'b0;
        @(negedge clk);
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        repeat (4) @(negedge clk);
        chk("mid_mp3_written", 64'(membrane_potential_out[3*MW +: MW]), 64'd3);
        chk("mid_mp4_pending", 64'(membrane_potential_out[4*MW +: MW]), 64'd0);
        chk("mid_busy", 64'(busy), 64'd1);
        reset = 1'b1;
        #1;
        chk("abort_mp", 64'(membrane_potential_out), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_spk", 64'(output_spikes), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        nr = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (output_data_ready) nr++;
        end
        chk("abort_no_ready", 64'(nr), 64'd0);
        run_step(lat);
        chk("after_abort_latency", 64'(lat), 64'd8);
        chk("after_abort_mp", 64'(membrane_potential_out), 64'({NO{5'd3}}));
        chk("after_abort_spk", 64'(output_spikes), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/snn_delay_layer_seq.md
# snn_delay_layer_seq

Parametrised, time-multiplexed leaky integrate-and-fire layer with per-synapse programmable spike delays and ternary weights. It is the generalised building block for stacking SNN layers of arbitrary width: one instance per layer, chained spike-to-spike. Each network time step is triggered by a `step` pulse. The layer then evaluates one neuron per clock and signals completion with a one-cycle `output_data_ready`.

## Interface
- `NUM_IN`, default 8: input spike channels (≥1).
- `NUM_OUT`, default 8: neurons in layer (≥1).
- `MP_WIDTH`, default 5: membrane potential width (unsigned).
- `DW`, default 3: delay value width; history depth 2^DW steps.
- `REF_WIDTH`, default 5: refractory counter width.
- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-high reset.
- `enable` in 1: global enable; low pauses the block.
- `step` in 1: start one time step; sampled only when idle.
- `input_spikes` in NUM_IN: spikes for this step.
- `weights` in NUM_IN*NUM_OUT*2: synapse s=j*NUM_IN+i at [2s+:2]. Bit 1 = zero flag (1 → contributes 0). Bit 0 = sign (0 → +1, 1 → −1).
- `delays` in NUM_IN*NUM_OUT*(DW+1): synapse s at [s*(DW+1)+:DW+1]. MSB = delay enable; low DW bits = delay value.
- `threshold` in MP_WIDTH: firing threshold.
- `decay` in MP_WIDTH: leak subtracted per step.
- `refractory_period` in REF_WIDTH: steps of refractoriness after a spike.
- `reset_mode` in 1: 0 = reset-to-zero, 1 = reset-by-subtraction.
- `membrane_potential_out` out NUM_OUT*MP_WIDTH: neuron j at [j*MP_WIDTH+:MP_WIDTH].
- `output_spikes` out NUM_OUT: registered spike vector of the last completed step.
- `busy` out 1: high while a step is being evaluated.
- `output_data_ready` out 1: one-cycle pulse when a step completes.

## Operation
- Reset clears all state: every potential, refractory counter, history bit, `output_spikes`, `busy` and `output_data_ready` = 0; FSM in IDLE.
- **History.** There is one shift register per input of depth 2^DW. `hist[i][0]` holds the current step's spike and `hist[i][k]` holds the spike from k steps earlier. The register shifts only when a step is accepted.
- **Synapse input.** A synapse with delay enable 0 uses `hist[i][0]`. A synapse with delay enable 1 and value d uses `hist[i][d]`; d=0 is equivalent to no delay.
- **Contribution.** Synapse (j,i) contributes 0 if its input spike is 0 or its zero flag is 1; otherwise +1 or −1 by its sign bit. `sum_j` is the signed sum over all NUM_IN synapses, range ±NUM_IN.
- **FSM states.**
  - IDLE: `busy`=0. `step`=1 and `enable`=1 → latch `input_spikes` into history, clear neuron index, go to EVAL.
  - EVAL: `busy`=1. Each enabled cycle updates neuron `idx`, then increments `idx`. After neuron NUM_OUT−1 → IDLE.
  - `enable`=0 in EVAL holds `idx` and all state.
- **Neuron update for neuron j (potential mp, refractory counter rc).**
  - If rc≠0: rc−1; mp unchanged; spike 0.
  - Else compute v = mp − decay + sum_j at full signed width (no intermediate overflow), then clamp to [0, 2^MP_WIDTH−1].
  - If v ≥ threshold: spike 1; rc = refractory_period; mp = 0 (reset_mode 0) or v − threshold (reset_mode 1).
  - Otherwise mp = v; spike 0.
- Per-neuron spikes collect in a shadow vector. `output_spikes` loads the shadow vector at the final EVAL edge, so the output vector changes atomically.
- `membrane_potential_out` reflects the registered potentials and updates neuron by neuron.
- `step` while busy, or while `enable`=0, is ignored and not queued.
- Parameter inputs (weights, delays, threshold, decay, refractory_period, reset_mode) are sampled combinationally during each neuron's EVAL cycle. They must be stable while `busy`=1.

## Timing
- Step accepted at rising edge k → `busy`=1 after edge k.
- Neuron j is written at edge k+1+j (with `enable` held high).
- At edge k+NUM_OUT: `output_spikes` updates, `output_data_ready`=1 for exactly one cycle, and `busy`=0.
- The next step is accepted at the earliest edge k+NUM_OUT+1. Throughput is one step per NUM_OUT+1 cycles.
- Each cycle with `enable` low during EVAL extends all later events by one cycle.
- Asynchronous reset mid-EVAL aborts the step immediately. No `output_data_ready` is produced, and the history is lost.

## Test plan
- **Basic fire.** NUM_IN=8, NUM_OUT=8. Threshold 3, decay 0, all weights +1 (2'b00), no delays, input 8'h07, one step. → Every neuron v=3, fires; `output_spikes`=8'hFF; potentials 0; ready pulse at edge k+8.
- **Delay.** Synapse (0,0) only: weight +1, delay enable 1, value 2; threshold 1; input bit0 on step 1 only, then 0. → Neuron 0 spikes only on step 3.
- **Leak/clamp/inhibit.** Weights −1 on neuron 1, input 8'hFF, decay 2, mp=0. → mp stays 0, no spike. Then weights +1, threshold 31, input 8'hFF for 5 steps, decay 0. → mp saturates at 31 and fires on step 4.
- **Refractory and reset_mode.** Refractory 2, threshold 3, sum 5 each step. → reset_mode 0 gives spikes on steps 1, 4, 7 with mp 0 after each spike. reset_mode 1 gives mp=2 after step 1.
- **Handshake.** Assert `step` every cycle. → Exactly one step accepted per 9 cycles. Drop `enable` for 3 cycles mid-EVAL → ready delayed by 3 cycles.
- **Reset mid-operation.** Assert `reset` at idx 4. → All outputs 0 immediately; no ready pulse; next step behaves as first after reset.
